// File: rtl/squirrel_rst_pkg.sv
// rtl/squirrel_rst_pkg.sv - shared types and constants for the Squirrel reset sequencer
package squirrel_rst_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK,
      RELEASE,
      RUN,
      HOLD
   } rst_seq_state_e;

   localparam int LockLossW = 8;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/squirrel_rst_seq_if.sv
// rtl/squirrel_rst_seq_if.sv - lock/request inputs and sequenced reset outputs of the reset sequencer
interface squirrel_rst_seq_if #(
   parameter int NumOut = 3
);
   import squirrel_rst_pkg::*;

   logic                 lock_i;
   logic                 sw_rst_req_i;
   logic [NumOut-1:0]    rst_no;
   logic                 rst_done_o;
   logic [LockLossW-1:0] lock_loss_o;

   modport master (
      output lock_i,
      output sw_rst_req_i,
      input  rst_no,
      input  rst_done_o,
      input  lock_loss_o
   );

   modport slave (
      input  lock_i,
      input  sw_rst_req_i,
      output rst_no,
      output rst_done_o,
      output lock_loss_o
   );

endinterface

// File: rtl/squirrel_sync_ff.sv
// rtl/squirrel_sync_ff.sv - multi-stage flop synchroniser for a single asynchronous bit
module squirrel_sync_ff #(
   parameter int   Stages   = 2,
   parameter logic ResetVal = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [Stages-1:0] sync_q;
   logic [Stages-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[Stages-2:0], d_i};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= {Stages{ResetVal}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/squirrel_rst_seq.sv
// rtl/squirrel_rst_seq.sv - qualifies MMCM lock and releases NumOut resets in order, counting lock losses
module squirrel_rst_seq
   import squirrel_rst_pkg::*;
#(
   parameter int NumOut     = 3,
   parameter int SyncStages = 2,
   parameter int LockFilter = 8,
   parameter int StageDelay = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   squirrel_rst_seq_if.slave  bus
);

   localparam int CntW = $clog2(max_int(LockFilter, StageDelay) + 1);
   localparam int IdxW = $clog2(NumOut + 1);

   localparam logic [CntW-1:0]      FiltLast = CntW'(LockFilter - 1);
   localparam logic [CntW-1:0]      DlyLast  = CntW'(StageDelay - 1);
   localparam logic [IdxW-1:0]      IdxLast  = IdxW'(NumOut - 1);
   localparam logic [LockLossW-1:0] LossMax  = '1;

   logic lock_sync;

   squirrel_sync_ff #(
      .Stages   (SyncStages),
      .ResetVal (1'b0)
   ) u_lock_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (bus.lock_i),
      .q_o    (lock_sync)
   );

   rst_seq_state_e       state_q,  state_d;
   logic [CntW-1:0]      filt_q,   filt_d;
   logic [CntW-1:0]      dly_q,    dly_d;
   logic [IdxW-1:0]      idx_q,    idx_d;
   logic [NumOut-1:0]    rst_no_q, rst_no_d;
   logic                 done_q,   done_d;
   logic [LockLossW-1:0] loss_q,   loss_d;
   logic                 abort;

   always_comb begin
      state_d  = state_q;
      filt_d   = filt_q;
      dly_d    = dly_q;
      idx_d    = idx_q;
      rst_no_d = rst_no_q;
      done_d   = done_q;
      loss_d   = loss_q;
      abort    = !lock_sync || bus.sw_rst_req_i;

      case (state_q)
         WAIT_LOCK: begin
            if (abort) begin
               filt_d = '0;
            end else if (filt_q == FiltLast) begin
               state_d = RELEASE;
               idx_d   = '0;
               dly_d   = '0;
            end else begin
               filt_d = filt_q + 1'b1;
            end
         end
         RELEASE, RUN: begin
            // Abort wins over a release due on the same edge, so no partial pattern survives.
            if (abort) begin
               state_d  = HOLD;
               dly_d    = '0;
               rst_no_d = '0;
               done_d   = 1'b0;
               if (!lock_sync && loss_q != LossMax) begin
                  loss_d = loss_q + 1'b1;
               end
            end else if (state_q == RELEASE) begin
               if (dly_q == DlyLast) begin
                  rst_no_d[idx_q] = 1'b1;
                  dly_d           = '0;
                  idx_d           = idx_q + 1'b1;
                  if (idx_q == IdxLast) begin
                     state_d = RUN;
                     done_d  = 1'b1;
                  end
               end else begin
                  dly_d = dly_q + 1'b1;
               end
            end
         end
         HOLD: begin
            // Fixed-length hold: inputs are deliberately ignored until it expires.
            if (dly_q == DlyLast) begin
               state_d = WAIT_LOCK;
               filt_d  = '0;
               dly_d   = '0;
            end else begin
               dly_d = dly_q + 1'b1;
            end
         end
         default: begin
            state_d = WAIT_LOCK;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= WAIT_LOCK;
         filt_q   <= '0;
         dly_q    <= '0;
         idx_q    <= '0;
         rst_no_q <= '0;
         done_q   <= 1'b0;
         loss_q   <= '0;
      end else begin
         state_q  <= state_d;
         filt_q   <= filt_d;
         dly_q    <= dly_d;
         idx_q    <= idx_d;
         rst_no_q <= rst_no_d;
         done_q   <= done_d;
         loss_q   <= loss_d;
      end
   end

   assign bus.rst_no      = rst_no_q;
   assign bus.rst_done_o  = done_q;
   assign bus.lock_loss_o = loss_q;

endmodule

// File: tb/tb_squirrel_rst_seq.sv
// tb/tb_squirrel_rst_seq.sv - scoreboard bench for the reset sequencer output events
module tb_squirrel_rst_seq;
   import squirrel_rst_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   squirrel_rst_seq_if #(.NumOut(3)) bus ();

   squirrel_rst_seq #(
      .NumOut     (3),
      .SyncStages (2),
      .LockFilter (8),
      .StageDelay (16)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   typedef struct {
      int         at;
      logic [2:0] rst;
      logic       done;
      logic [7:0] loss;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   base;
   int   b2;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic push(input int at, input logic [2:0] r, input logic d, input logic [7:0] l);
      exp_t e;
      e.at   = at;
      e.rst  = r;
      e.done = d;
      e.loss = l;
      exp_q.push_back(e);
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic drain(input string tag);
      check_eq(tag, exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Every output change must match the next expected event, including its edge number.
   logic [11:0] prev_v = '0;
   logic [11:0] mon_cur;
   exp_t        mon_e;

   always @(posedge clk) begin
      #1;
      mon_cur = {bus.rst_no, bus.rst_done_o, bus.lock_loss_o};
      if (rst_n && mon_cur !== prev_v) begin
         if (exp_q.size() == 0) begin
            check_eq("unexp_evt", mon_cur, prev_v);
         end else begin
            mon_e = exp_q.pop_front();
            check_eq("evt_cyc",  cyc,             mon_e.at);
            check_eq("evt_rst",  bus.rst_no,      mon_e.rst);
            check_eq("evt_done", bus.rst_done_o,  mon_e.done);
            check_eq("evt_loss", bus.lock_loss_o, mon_e.loss);
         end
      end
      prev_v = mon_cur;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete (cyc %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.lock_i       = 1'b0;
      bus.sw_rst_req_i = 1'b0;
      rst_n            = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("reset_rst_no", bus.rst_no,      0);
      check_eq("reset_done",   bus.rst_done_o,  0);
      check_eq("reset_loss",   bus.lock_loss_o, 0);

      // Power-up sequencing
      rst_n      = 1'b1;
      bus.lock_i = 1'b1;
      base       = cyc;
      push(base + 26, 3'b001, 1'b0, 8'd0);
      push(base + 42, 3'b011, 1'b0, 8'd0);
      push(base + 58, 3'b111, 1'b1, 8'd0);
      wait_to(base + 62);
      drain("powerup_drain");

      // Lock loss in RUN, lock back during HOLD
      bus.lock_i = 1'b0;
      base       = cyc;
      push(base + 3,  3'b000, 1'b0, 8'd1);
      push(base + 43, 3'b001, 1'b0, 8'd1);
      push(base + 59, 3'b011, 1'b0, 8'd1);
      push(base + 75, 3'b111, 1'b1, 8'd1);
      wait_to(base + 4);
      bus.lock_i = 1'b1;
      wait_to(base + 80);
      drain("lockloss_drain");

      // Software pulse in RUN, then again mid-RELEASE with only output 0 released
      bus.sw_rst_req_i = 1'b1;
      base             = cyc;
      push(base + 1,  3'b000, 1'b0, 8'd1);
      push(base + 41, 3'b001, 1'b0, 8'd1);
      @(negedge clk);
      bus.sw_rst_req_i = 1'b0;
      wait_to(base + 41);
      bus.sw_rst_req_i = 1'b1;
      b2               = cyc;
      push(b2 + 1,  3'b000, 1'b0, 8'd1);
      push(b2 + 41, 3'b001, 1'b0, 8'd1);
      push(b2 + 57, 3'b011, 1'b0, 8'd1);
      push(b2 + 73, 3'b111, 1'b1, 8'd1);
      @(negedge clk);
      bus.sw_rst_req_i = 1'b0;
      wait_to(b2 + 78);
      drain("swreq_drain");

      // Lock glitch while filtering restarts the filter
      rst_n      = 1'b0;
      bus.lock_i = 1'b0;
      repeat (3) @(negedge clk);
      rst_n      = 1'b1;
      bus.lock_i = 1'b1;
      base       = cyc;
      wait_to(base + 5);
      bus.lock_i = 1'b0;
      wait_to(base + 8);
      bus.lock_i = 1'b1;
      b2         = cyc;
      push(b2 + 26, 3'b001, 1'b0, 8'd0);
      push(b2 + 42, 3'b011, 1'b0, 8'd0);
      push(b2 + 58, 3'b111, 1'b1, 8'd0);
      wait_to(b2 + 62);
      drain("glitch_drain");

      // 300 lock losses: counter saturates at 255 with no further output change
      for (int n = 1; n <= 300; n++) begin
         bus.lock_i = 1'b0;
         base       = cyc;
         if (n <= 255) push(base + 3, 3'b000, 1'b0, 8'(n));
         wait_to(base + 4);
         bus.lock_i = 1'b1;
         wait_to(base + 30);
      end
      push(base + 43, 3'b001, 1'b0, 8'd255);
      wait_to(base + 50);
      check_eq("sat_loss", bus.lock_loss_o, 255);
      drain("sat_drain");

      // Async reset mid-RELEASE clears outputs without a clock edge
      rst_n = 1'b0;
      #1;
      check_eq("async_rst_no", bus.rst_no,      0);
      check_eq("async_done",   bus.rst_done_o,  0);
      check_eq("async_loss",   bus.lock_loss_o, 0);
      check_eq("async_state",  32'(dut.state_q), 32'(WAIT_LOCK));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      base  = cyc;
      push(base + 26, 3'b001, 1'b0, 8'd0);
      push(base + 42, 3'b011, 1'b0, 8'd0);
      push(base + 58, 3'b111, 1'b1, 8'd0);
      wait_to(base + 62);
      drain("post_rst_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
